// File: rtl/adder_share_arbiter_pkg.sv
// Shared definitions for the adder sharing arbiter: datapath width, FSM encoding
// and a clog2 helper used to validate the requester-id width.
package adder_share_arbiter_pkg;

  localparam int unsigned ADD_W = 32;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StExec = 2'd1,
    StResp = 2'd2
  } state_e;

  // Ceiling log2 with a floor of 1 so a two-requester build still gets a 1-bit id.
  function automatic int unsigned clog2(input int unsigned n);
    int unsigned r;
    r = 1;
    for (int i = 1; i < 32; i++) begin
      if ((longint'(1) << i) < longint'(n)) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/bitcarryselect.sv
// 32-bit carry-select adder: 4-bit blocks precompute both carry-in cases and the
// incoming block carry picks one. No carry-in; carry out of bit 31 on cout.
module bitcarryselect (
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic [31:0] sum,
  output logic        cout
);

  localparam int unsigned BLK  = 4;
  localparam int unsigned NBLK = 32 / BLK;

  logic [NBLK:0] c;

  assign c[0] = 1'b0;

  for (genvar i = 0; i < NBLK; i++) begin : g_blk
    logic [BLK:0] s0;
    logic [BLK:0] s1;

    assign s0 = {1'b0, a[i*BLK +: BLK]} + {1'b0, b[i*BLK +: BLK]};
    assign s1 = {1'b0, a[i*BLK +: BLK]} + {1'b0, b[i*BLK +: BLK]} + {{BLK{1'b0}}, 1'b1};

    assign sum[i*BLK +: BLK] = c[i] ? s1[BLK-1:0] : s0[BLK-1:0];
    assign c[i+1]            = c[i] ? s1[BLK] : s0[BLK];
  end

  assign cout = c[NBLK];

endmodule

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: the first set request searching upward from
// ptr+1 (mod NREQ) wins; outputs a one-hot grant and its binary index.
module rr_arbiter #(
  parameter int unsigned NREQ = 4,
  parameter int unsigned IDW  = 2
) (
  input  logic [NREQ-1:0] req,
  input  logic [IDW-1:0]  ptr,
  input  logic            en,
  output logic [NREQ-1:0] gnt,
  output logic [IDW-1:0]  idx
);

  logic [31:0] j;

  // Scan from the farthest candidate back to the nearest so the nearest match wins.
  always_comb begin
    gnt = '0;
    idx = '0;
    j   = '0;
    for (int k = NREQ; k >= 1; k--) begin
      j = (32'(ptr) + 32'(k)) % NREQ;
      if (en && req[j[IDW-1:0]]) begin
        gnt              = '0;
        gnt[j[IDW-1:0]]  = 1'b1;
        idx              = j[IDW-1:0];
      end
    end
  end

endmodule

// File: rtl/adder_share_arbiter.sv
// Shares one bitcarryselect adder among NREQ requesters with round-robin
// arbitration, registered operands and a registered, tagged response.
module adder_share_arbiter
  import adder_share_arbiter_pkg::*;
#(
  parameter int unsigned NREQ = 4,
  parameter int unsigned IDW  = 2,
  parameter int unsigned CNTW = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [NREQ-1:0]       req_valid,
  output logic [NREQ-1:0]       req_ready,
  input  logic [NREQ*ADD_W-1:0] req_a,
  input  logic [NREQ*ADD_W-1:0] req_b,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [IDW-1:0]        rsp_id,
  output logic [ADD_W-1:0]      rsp_sum,
  output logic                  rsp_cout,
  output logic                  busy,
  output logic [CNTW-1:0]       ops_done
);

  if (IDW != clog2(NREQ) || NREQ < 2 || NREQ > 8) begin : g_param_check
    $error("adder_share_arbiter: NREQ must be 2..8 and IDW must equal clog2(NREQ)");
  end

  state_e            state_q, state_d;
  logic [IDW-1:0]    ptr_q, id_q, gnt_idx;
  logic [NREQ-1:0]   gnt;
  logic [ADD_W-1:0]  a_q, b_q, a_sel, b_sel, add_sum, sum_q;
  logic              add_cout, cout_q, rsp_valid_q;
  logic [IDW-1:0]    rsp_id_q;
  logic [CNTW-1:0]   ops_q;

  rr_arbiter #(
    .NREQ (NREQ),
    .IDW  (IDW)
  ) u_arb (
    .req (req_valid),
    .ptr (ptr_q),
    .en  (state_q == StIdle),
    .gnt (gnt),
    .idx (gnt_idx)
  );

  // One-hot grant makes OR-ing the selected slices a plain mux.
  always_comb begin
    a_sel = '0;
    b_sel = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (gnt[i]) begin
        a_sel = a_sel | req_a[i*ADD_W +: ADD_W];
        b_sel = b_sel | req_b[i*ADD_W +: ADD_W];
      end
    end
  end

  bitcarryselect u_add (
    .a    (a_q),
    .b    (b_q),
    .sum  (add_sum),
    .cout (add_cout)
  );

  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle:  if (|gnt) state_d = StExec;
      StExec:  state_d = StResp;
      StResp:  if (rsp_ready) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      ptr_q       <= IDW'(NREQ - 1);
      id_q        <= '0;
      a_q         <= '0;
      b_q         <= '0;
      rsp_valid_q <= 1'b0;
      rsp_id_q    <= '0;
      sum_q       <= '0;
      cout_q      <= 1'b0;
      ops_q       <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == StIdle && |gnt) begin
        a_q   <= a_sel;
        b_q   <= b_sel;
        id_q  <= gnt_idx;
        ptr_q <= gnt_idx;
      end
      if (state_q == StExec) begin
        sum_q       <= add_sum;
        cout_q      <= add_cout;
        rsp_id_q    <= id_q;
        rsp_valid_q <= 1'b1;
      end
      if (state_q == StResp && rsp_ready) begin
        rsp_valid_q <= 1'b0;
        if (ops_q != '1) ops_q <= ops_q + CNTW'(1);
      end
    end
  end

  assign req_ready = gnt;
  assign rsp_valid = rsp_valid_q;
  assign rsp_id    = rsp_id_q;
  assign rsp_sum   = sum_q;
  assign rsp_cout  = cout_q;
  assign busy      = (state_q != StIdle);
  assign ops_done  = ops_q;

endmodule

// File: tb/tb_adder_share_arbiter.sv
// Self-checking bench: directed scenarios plus randomized traffic against a
// transaction-level model; a second instance with a 2-bit counter checks saturation.
module tb_adder_share_arbiter;

  localparam int NREQ = 4;
  localparam int IDW  = 2;
  localparam int CNTW = 16;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic [NREQ-1:0]   req_valid, req_ready, req_ready_s;
  logic [31:0]       opa[NREQ];
  logic [31:0]       opb[NREQ];
  logic [NREQ*32-1:0] req_a, req_b;
  logic              rsp_ready;
  logic              rsp_valid, rsp_cout, busy;
  logic [IDW-1:0]    rsp_id;
  logic [31:0]       rsp_sum;
  logic [CNTW-1:0]   ops_done;
  logic              rsp_valid_s, rsp_cout_s, busy_s;
  logic [IDW-1:0]    rsp_id_s;
  logic [31:0]       rsp_sum_s;
  logic [1:0]        ops_done_s;

  always #5 clk = ~clk;

  always_comb begin
    req_a = '0;
    req_b = '0;
    for (int i = 0; i < NREQ; i++) begin
      req_a[i*32 +: 32] = opa[i];
      req_b[i*32 +: 32] = opb[i];
    end
  end

  adder_share_arbiter #(.NREQ(NREQ), .IDW(IDW), .CNTW(CNTW)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_id(rsp_id), .rsp_sum(rsp_sum), .rsp_cout(rsp_cout), .busy(busy),
    .ops_done(ops_done)
  );

  adder_share_arbiter #(.NREQ(NREQ), .IDW(IDW), .CNTW(2)) dut_sat (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready_s),
    .req_a(req_a), .req_b(req_b), .rsp_valid(rsp_valid_s), .rsp_ready(rsp_ready),
    .rsp_id(rsp_id_s), .rsp_sum(rsp_sum_s), .rsp_cout(rsp_cout_s), .busy(busy_s),
    .ops_done(ops_done_s)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Transaction-level model: phase counts cycles since acceptance (0 = free).
  typedef struct {
    int         id;
    logic [32:0] res;
  } rsp_t;

  int   m_phase, m_ptr, m_ops;
  rsp_t exp_q[$];
  int   grants[$];
  logic [31:0] obs_sum[$];
  int   wait_cnt[NREQ];

  function automatic int winner();
    for (int k = 1; k <= NREQ; k++) begin
      if (req_valid[(m_ptr + k) % NREQ]) return (m_ptr + k) % NREQ;
    end
    return -1;
  endfunction

  task automatic model_reset();
    m_phase = 0;
    m_ptr   = NREQ - 1;
    m_ops   = 0;
    exp_q.delete();
    for (int i = 0; i < NREQ; i++) wait_cnt[i] = 0;
  endtask

  // Called at a negedge with inputs already applied; returns at the next negedge.
  task automatic cycle();
    int w, g_obs;
    logic [NREQ-1:0] er;
    rsp_t t;
    #1;
    w  = (m_phase == 0) ? winner() : -1;
    er = '0;
    if (w >= 0) er[w] = 1'b1;
    check("req_ready", req_ready, er);
    check("busy", busy, m_phase != 0);
    check("rsp_valid", rsp_valid, m_phase == 2);
    if (m_phase == 2) begin
      check("rsp_id", rsp_id, exp_q[0].id);
      check("rsp_sum", rsp_sum, exp_q[0].res[31:0]);
      check("rsp_cout", rsp_cout, exp_q[0].res[32]);
    end
    check("ops_done", ops_done, m_ops);
    check("ops_done_sat", ops_done_s, (m_ops > 3) ? 3 : m_ops);
    check("rsp_valid_sat", rsp_valid_s, m_phase == 2);
    g_obs = -1;
    for (int i = 0; i < NREQ; i++) if (req_ready[i]) g_obs = i;
    if (m_phase == 2 && rsp_ready) obs_sum.push_back(rsp_sum);
    @(posedge clk);
    if (g_obs >= 0) begin
      check("fairness", wait_cnt[g_obs] < NREQ, 1'b1);
      for (int i = 0; i < NREQ; i++) if (i != g_obs && req_valid[i]) wait_cnt[i]++;
      wait_cnt[g_obs] = 0;
    end
    for (int i = 0; i < NREQ; i++) if (!req_valid[i]) wait_cnt[i] = 0;
    if (w >= 0) begin
      t.id  = w;
      t.res = {1'b0, opa[w]} + {1'b0, opb[w]};
      exp_q.push_back(t);
      grants.push_back(w);
      m_ptr   = w;
      m_phase = 1;
    end else if (m_phase == 1) begin
      m_phase = 2;
    end else if (m_phase == 2 && rsp_ready) begin
      void'(exp_q.pop_front());
      m_ops++;
      m_phase = 0;
    end
    @(negedge clk);
  endtask

  // Called at a negedge; reset effects are checked before any clock edge.
  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    check("rst_rsp_valid", rsp_valid, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_ops_done", ops_done, 0);
    check("rst_rsp_id", rsp_id, 0);
    check("rst_rsp_sum", rsp_sum, 0);
    check("rst_rsp_cout", rsp_cout, 1'b0);
    model_reset();
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    int exp_rr[5];
    int exp_sat[5];
    int exp_sum[5];
    exp_rr  = '{0, 1, 2, 3, 0};
    exp_sat = '{1, 2, 3, 3, 3};
    exp_sum = '{100, 101, 102, 103, 100};
    req_valid = '0;
    rsp_ready = 1'b0;
    for (int i = 0; i < NREQ; i++) begin
      opa[i] = '0;
      opb[i] = '0;
    end
    @(negedge clk);
    do_reset();
    repeat (3) cycle();

    // Single op with overflow from requester 2.
    grants.delete();
    opa[2] = 32'hFFFF_FFFF;
    opb[2] = 32'h0000_0001;
    req_valid = 4'b0100;
    rsp_ready = 1'b1;
    cycle();
    req_valid = '0;
    cycle();
    cycle();
    check("ovf_grant_cnt", grants.size(), 1);
    if (grants.size() == 1) check("ovf_grant_id", grants[0], 2);
    check("ovf_sum", rsp_sum, 32'h0);
    check("ovf_cout", rsp_cout, 1'b1);
    check("ovf_id", rsp_id, 2);
    check("ovf_ops", ops_done, 1);

    // Round robin with all requesters pending from reset.
    do_reset();
    grants.delete();
    obs_sum.delete();
    for (int i = 0; i < NREQ; i++) begin
      opa[i] = i;
      opb[i] = 100;
    end
    req_valid = 4'hF;
    repeat (15) cycle();
    req_valid = '0;
    repeat (3) cycle();
    check("rr_grant_cnt", grants.size(), 5);
    check("rr_sum_cnt", obs_sum.size(), 5);
    for (int k = 0; k < 5; k++) begin
      if (k < grants.size()) check("rr_grant", grants[k], exp_rr[k]);
      if (k < obs_sum.size()) check("rr_sum", obs_sum[k], exp_sum[k]);
    end

    // Backpressure with requester 1 waiting behind a stalled response.
    do_reset();
    grants.delete();
    opa[0] = 32'h8000_0000;
    opb[0] = 32'h8000_0000;
    opa[1] = 32'd5;
    opb[1] = 32'd6;
    rsp_ready = 1'b0;
    req_valid = 4'b0011;
    cycle();
    req_valid = 4'b0010;
    cycle();
    repeat (5) begin
      cycle();
      check("bp_sum", rsp_sum, 32'h0);
      check("bp_cout", rsp_cout, 1'b1);
      check("bp_valid", rsp_valid, 1'b1);
      check("bp_busy", busy, 1'b1);
      check("bp_ready", req_ready, '0);
    end
    rsp_ready = 1'b1;
    cycle();
    cycle();
    req_valid = '0;
    repeat (3) cycle();
    check("bp_grant_cnt", grants.size(), 2);
    if (grants.size() == 2) check("bp_next_grant", grants[1], 1);

    // Requester 3 pulses during EXEC and withdraws.
    do_reset();
    grants.delete();
    opa[0] = 32'd7;
    opb[0] = 32'd8;
    opa[3] = 32'd1;
    opb[3] = 32'd1;
    req_valid = 4'b0001;
    cycle();
    req_valid = 4'b1000;
    cycle();
    req_valid = '0;
    repeat (4) cycle();
    check("wd_grant_cnt", grants.size(), 1);
    if (grants.size() == 1) check("wd_grant_id", grants[0], 0);
    check("wd_ops", ops_done, 1);

    // Saturating 2-bit counter over five operations.
    do_reset();
    for (int n = 0; n < 5; n++) begin
      opa[1] = n;
      opb[1] = 32'd3;
      req_valid = 4'b0010;
      cycle();
      req_valid = '0;
      cycle();
      cycle();
      check("sat_seq", ops_done_s, exp_sat[n]);
    end

    // Reset while a response is stalled in RESP.
    opa[2] = 32'h1234_5678;
    opb[2] = 32'h1111_1111;
    rsp_ready = 1'b0;
    req_valid = 4'b0100;
    cycle();
    req_valid = '0;
    cycle();
    cycle();
    check("pre_rst_valid", rsp_valid, 1'b1);
    do_reset();
    rsp_ready = 1'b1;
    repeat (3) cycle();
    check("post_rst_ready", req_ready, '0);
    check("post_rst_ops", ops_done, 0);

    // Randomized traffic with sticky requests so the fairness bound is exercised.
    do_reset();
    req_valid = '0;
    repeat (3000) begin
      for (int i = 0; i < NREQ; i++) begin
        if ($urandom_range(0, 5) == 0) req_valid[i] = ~req_valid[i];
        case ($urandom_range(0, 3))
          0:       opa[i] = 32'hFFFF_FFFF;
          1:       opa[i] = 32'h0;
          default: opa[i] = $urandom;
        endcase
        opb[i] = $urandom;
      end
      rsp_ready = ($urandom_range(0, 3) != 0);
      cycle();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
